// File: rtl/imem_loader.sv
// imem_loader: turns a framed byte stream into 32-bit instruction-RAM writes.
// Frame: SYNC, LEN_HI, LEN_LO, LEN*4 data bytes (MSB first), CHK.
// CHK is the 8-bit sum of the data bytes. The CPU is held in reset while a
// load is in progress and after an aborted load.
module imem_loader #(
  parameter int          DEPTH   = 128,
  parameter int          AW      = 7,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          TIMEOUT = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

  state_t      state, nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [7:0]  chk;
  logic [23:0] asm_r;
  logic [31:0] tcnt;
  logic        timed_out;
  logic        is_sync;

  assign len_in    = {len_hi, rx_data};
  assign is_sync   = rx_valid && (rx_data == SYNC);
  // The edge that would take the idle counter to TIMEOUT is the abort edge.
  assign timed_out = !rx_valid && (tcnt == TLIM);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (is_sync) nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid)       nxt = S_LEN_LO;
        else if (timed_out) nxt = S_ERR;
      end
      S_LEN_LO: begin
        if (rx_valid)
          nxt = (len_in == 16'd0 || len_in > 16'(DEPTH)) ? S_ERR : S_DATA;
        else if (timed_out)
          nxt = S_ERR;
      end
      S_DATA: begin
        if (rx_valid && bcnt == 2'd3 && wcnt == len - 16'd1) nxt = S_CHK;
        else if (timed_out)                                 nxt = S_ERR;
      end
      S_CHK: begin
        if (rx_valid)       nxt = (rx_data == chk) ? S_DONE : S_ERR;
        else if (timed_out) nxt = S_ERR;
      end
      default: nxt = S_IDLE;
    endcase
    busy      = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                (state == S_DATA)   || (state == S_CHK);
    cpu_reset = busy || (state == S_ERR);
    done      = (state == S_DONE);
    error     = (state == S_ERR);
  end

  // Datapath: length latch, word assembly, checksum, write port, idle timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      we     <= 1'b0;
      wa     <= '0;
      wd     <= '0;
      len_hi <= '0;
      len    <= '0;
      wcnt   <= '0;
      bcnt   <= '0;
      chk    <= '0;
      asm_r  <= '0;
      tcnt   <= '0;
    end else begin
      we <= 1'b0;
      if (busy && !rx_valid) tcnt <= tcnt + 32'd1;
      else                   tcnt <= '0;
      if (rx_valid) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_sync) begin
              chk  <= '0;
              wcnt <= '0;
              bcnt <= '0;
            end
          end
          S_LEN_HI: len_hi <= rx_data;
          S_LEN_LO: len    <= len_in;
          S_DATA: begin
            asm_r <= {asm_r[15:0], rx_data};
            chk   <= chk + rx_data;
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              we   <= 1'b1;
              wa   <= wcnt[AW-1:0];
              wd   <= {asm_r, rx_data};
              wcnt <= wcnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction store. Receives a framed byte stream, for example from the UART/keyboard byte receiver, and assembles 32-bit ARM instruction words.
- Writes each word into the writable instruction RAM through a word-addressed write port. The processor's word-aligned read port (byte address bits [31:2]) sees the same word indices.
- Holds the CPU in reset while a load is in progress, so new programs load without resynthesis.

Parameters:
- DEPTH, 128, number of instruction words in the target RAM; maximum accepted frame length.
- AW, 7, width of the word address; clog2(DEPTH).
- SYNC, 8'hA5, frame start byte.
- TIMEOUT, 50_000_000, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per byte; back-to-back strobes allowed.
- we  out  1  instruction RAM write enable, one-cycle pulse per word.
- wa  out  AW  word address (RAM index) for the write.
- wd  out  32  instruction word to write.
- cpu_reset  out  1  held high to keep the processor in reset.
- busy  out  1  frame in progress.
- done  out  1  last frame completed with a good checksum.
- error  out  1  last frame aborted.

Behaviour:
- One clock domain; reset is synchronous and active-high, with clock port clk and reset port reset.
- Frame format: SYNC, LEN_HI, LEN_LO, then N=LEN*4 data bytes, then CHK.
  - Words are sent most-significant byte first.
  - CHK = 8-bit modulo-256 sum of all data bytes. Header bytes are excluded.
- Reset values: state IDLE; we=0, wa=0, wd=0, cpu_reset=0, busy=0, done=0, error=0. Word counter, byte counter, checksum accumulator and timeout counter are all 0.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
  - IDLE: a byte equal to SYNC goes to LEN_HI and clears the checksum, word index and done/error. Any other byte is ignored.
  - LEN_HI: latch the high length byte, then go to LEN_LO.
  - LEN_LO: form the 16-bit length. If LEN=0 or LEN>DEPTH, go to ERR. Otherwise go to DATA.
  - DATA: shift each byte into a 32-bit assembly register and add it to the checksum.
    - On the 4th byte of a word, the next cycle drives we=1, wa=word index, wd=assembled word. Write latency is 1 cycle after the strobe of the 4th byte.
    - The word index increments after each write.
    - After LEN words, go to CHK. The last write pulse may coincide with the CHK state.
  - CHK: if the byte equals the checksum, go to DONE. Otherwise go to ERR.
  - DONE: done=1. A SYNC byte starts a new frame. Any other byte is ignored.
  - ERR: error=1. Only a SYNC byte (starting a new frame) or reset leaves ERR. Any other byte is ignored.
- busy=1 in LEN_HI, LEN_LO, DATA and CHK.
- cpu_reset:
  - 1 in LEN_HI, LEN_LO, DATA, CHK and ERR, because a partial program must not execute.
  - 0 in IDLE and DONE.
  - It rises the cycle after SYNC is accepted and falls on entry to DONE.
- Timeout:
  - While busy, the counter increments every cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT, go to ERR. No further writes occur.
- Timing boundaries:
  - Back-to-back rx_valid strobes are lossless.
  - A write pulse never coincides with a second write pulse.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. we is never asserted in the cycle after reset. Words already written stay in the RAM.
- wa never exceeds DEPTH-1. wd and wa hold their last values when we=0.

Test Plan:
- Good 2-word load: A5 00 02 E3 A0 00 78 E3 A0 1E 4B E7 sent back-to-back -> we pulses at wa=0 wd=E3A00078 and wa=1 wd=E3A01E4B. Then done=1, cpu_reset=0, error=0.
- Bad checksum: same frame with last byte E6 -> both writes still occur; then error=1, cpu_reset=1, done=0. A following good frame clears error and ends with done=1.
- Length bounds: A5 00 00 -> error after LEN_LO with no we. A5 00 81 with DEPTH=128 -> error with no we. A5 00 80 followed by 512 bytes and a correct CHK -> last write at wa=127, then done=1.
- Noise before sync: 00 FF 5A 3C followed by a valid 1-word frame -> preamble ignored, with busy=0 and cpu_reset=0 throughout it. Then one write and done=1.
- Timeout with TIMEOUT=16: A5 00 01 E3 A0 00, then silence -> error=1 exactly 16 cycles after the last strobe, no we.
- Reset mid-frame: assert reset after the 2nd data byte -> next cycle IDLE, we=0, cpu_reset=0, busy=0. A subsequent full frame loads correctly from wa=0.
